shift_loader: RTL and testbench

Parallel-to-serial loader that feeds the serial shift-register stage. It accepts a WIDTH-bit word over a valid/ready handshake and drives `d`, `en` and `dir` for exactly WIDTH consecutive cycles. After those cycles the downstream register holds the word in its original bit order. It then pulses `frame_done` and enforces a programmable idle gap before it accepts the next word.

---
 rtl/shift_loader_if.sv | 26 ++
 rtl/shift_loader.sv | 167 ++++++++++++++++
 tb/tb_shift_loader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_loader_if.sv
// Upstream word handshake between a word producer and shift_loader.
// The producer uses the master modport, the loader uses the slave modport.
interface shift_loader_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;

    modport master (
        output in_valid,
        output in_data,
        output in_dir,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_dir,
        output in_ready
    );

endinterface

// File: rtl/shift_loader.sv
// shift_loader: parallel-to-serial loader feeding a WIDTH-bit serial shift register.
// A word accepted over the handshake is driven out on d/en/dir for exactly WIDTH
// cycles. That is followed by a one-cycle frame_done pulse and a GAP-cycle idle
// gap before the next word can be accepted.
// WIDTH must be >= 2 and GAP must be >= 1.
module shift_loader #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GAP   = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    shift_loader_if.slave i_bus,
    output logic          o_d,
    output logic          o_en,
    output logic          o_dir,
    output logic          o_busy,
    output logic          o_frame_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned GAP_W = $clog2(GAP + 1);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // State and datapath registers.
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_word;
    logic             r_dir;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [GAP_W-1:0] r_gap_cnt;

    // Registered outputs.
    logic             r_d;
    logic             r_en;
    logic             r_frame_done;
    logic             r_in_ready;

    // Next-state values.
    logic [1:0]       w_state;
    logic [WIDTH-1:0] w_word;
    logic             w_dir;
    logic [CNT_W-1:0] w_bit_cnt;
    logic [GAP_W-1:0] w_gap_cnt;
    logic             w_d;
    logic             w_en;
    logic             w_frame_done;
    logic             w_in_ready;

    logic             w_accept;
    logic [WIDTH-1:0] w_word_shifted;
    logic             w_next_bit;

    // r_in_ready is only ever set while idle, so it alone qualifies the handshake.
    assign w_accept = i_bus.in_valid && r_in_ready && (r_state == ST_IDLE);

    // The word register is shifted so the bit to send next always sits at a fixed
    // position next to the one currently on d: bit WIDTH-2 for MSB-first, bit 1
    // for LSB-first.
    assign w_word_shifted = r_dir ? (r_word >> 1) : (r_word << 1);
    assign w_next_bit     = r_dir ? r_word[1] : r_word[WIDTH-2];

    // Next-state and next-output decode for the IDLE/SHIFT/GAP sequence.
    always_comb begin
        w_state      = r_state;
        w_word       = r_word;
        w_dir        = r_dir;
        w_bit_cnt    = r_bit_cnt;
        w_gap_cnt    = r_gap_cnt;
        w_d          = r_d;
        w_en         = r_en;
        w_frame_done = 1'b0;
        w_in_ready   = r_in_ready;

        case (r_state)
            ST_IDLE: begin
                w_en       = 1'b0;
                w_d        = 1'b0;
                w_in_ready = 1'b1;
                if (w_accept) begin
                    w_word     = i_bus.in_data;
                    w_dir      = i_bus.in_dir;
                    w_bit_cnt  = '0;
                    // Shift 0 goes out in the cycle right after the handshake.
                    w_d        = i_bus.in_dir ? i_bus.in_data[0] : i_bus.in_data[WIDTH-1];
                    w_en       = 1'b1;
                    w_in_ready = 1'b0;
                    w_state    = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                w_in_ready = 1'b0;
                if (r_bit_cnt == BIT_LAST) begin
                    // Last shift is on d now; the downstream register is full
                    // after this edge.
                    w_en         = 1'b0;
                    w_d          = 1'b0;
                    w_frame_done = 1'b1;
                    w_gap_cnt    = '0;
                    w_state      = ST_GAP;
                end else begin
                    w_bit_cnt = r_bit_cnt + 1'b1;
                    w_word    = w_word_shifted;
                    w_d       = w_next_bit;
                    w_en      = 1'b1;
                end
            end

            ST_GAP: begin
                w_en       = 1'b0;
                w_d        = 1'b0;
                w_in_ready = 1'b0;
                if (r_gap_cnt == GAP_LAST) begin
                    w_in_ready = 1'b1;
                    w_state    = ST_IDLE;
                end else begin
                    w_gap_cnt = r_gap_cnt + 1'b1;
                end
            end

            default: begin
                w_en       = 1'b0;
                w_d        = 1'b0;
                w_in_ready = 1'b0;
                w_state    = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset drops any partial frame without frame_done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_word       <= '0;
            r_dir        <= 1'b0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_d          <= 1'b0;
            r_en         <= 1'b0;
            r_frame_done <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_word       <= w_word;
            r_dir        <= w_dir;
            r_bit_cnt    <= w_bit_cnt;
            r_gap_cnt    <= w_gap_cnt;
            r_d          <= w_d;
            r_en         <= w_en;
            r_frame_done <= w_frame_done;
            r_in_ready   <= w_in_ready;
        end
    end

    assign i_bus.in_ready = r_in_ready;
    assign o_d            = r_d;
    assign o_en           = r_en;
    assign o_dir          = r_dir;
    assign o_frame_done   = r_frame_done;
    assign o_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_shift_loader.sv
// Bench for shift_loader: directed vector table, hand-written corner sequences and
// randomized traffic, all checked cycle by cycle against a queue-based frame model.
module tb_shift_loader;

    localparam int unsigned W = 16;
    localparam int unsigned G = 2;

    typedef struct packed {
        logic en;
        logic d;
        logic dir;
        logic fd;
        logic busy;
    } exp_t;

    typedef struct {
        logic [W-1:0] data;
        logic         dir;
        logic [W-1:0] stream;  // expected d sequence, first shift in the MSB
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d, en, dir, busy, fd;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    shift_loader_if #(.WIDTH(W)) bus ();

    shift_loader #(
        .WIDTH(W),
        .GAP  (G)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_bus       (bus),
        .o_d         (d),
        .o_en        (en),
        .o_dir       (dir),
        .o_busy      (busy),
        .o_frame_done(fd)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%b want=%b", nm, cyc, act, exp);
        end
    endtask

    task automatic check_val(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: a handshake enqueues the whole frame's expected outputs.
    exp_t         q[$];
    exp_t         cur     = '0;
    logic         m_ready = 1'b0;
    logic         m_dir   = 1'b0;
    logic [W-1:0] m_word  = '0;

    initial forever begin
        exp_t e;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            cur     = '0;
            m_ready = 1'b0;
            m_dir   = 1'b0;
        end else if (q.size() != 0) begin
            cur     = q.pop_front();
            m_ready = 1'b0;
        end else if (m_ready && bus.in_valid) begin
            m_word = bus.in_data;
            m_dir  = bus.in_dir;
            for (int k = 0; k < W; k++) begin
                e.en   = 1'b1;
                e.d    = m_dir ? m_word[k] : m_word[W-1-k];
                e.dir  = m_dir;
                e.fd   = 1'b0;
                e.busy = 1'b1;
                q.push_back(e);
            end
            for (int g = 0; g < G; g++) begin
                e.en   = 1'b0;
                e.d    = 1'b0;
                e.dir  = m_dir;
                e.fd   = (g == 0);
                e.busy = 1'b1;
                q.push_back(e);
            end
            cur     = q.pop_front();
            m_ready = 1'b0;
        end else begin
            cur.en   = 1'b0;
            cur.d    = 1'b0;
            cur.dir  = m_dir;
            cur.fd   = 1'b0;
            cur.busy = 1'b0;
            m_ready  = 1'b1;
        end
    end

    // Downstream shift register driven by the DUT outputs.
    logic [W-1:0] sr = '0;
    always @(posedge clk) begin
        if (en) sr <= dir ? {d, sr[W-1:1]} : {sr[W-2:0], d};
    end

    // Per-cycle monitor, sampled 1 time unit after the rising edge.
    logic         prev_en    = 1'b0;
    int           en_rises   = 0;
    int           fd_count   = 0;
    int           low_run    = 0;
    int           last_low   = 0;
    int           rise_cyc[$];
    logic [W-1:0] stream_cap = '0;

    initial forever begin
        @(posedge clk);
        #1;
        check_bit("en", en, cur.en);
        check_bit("d", d, cur.d);
        check_bit("dir", dir, cur.dir);
        check_bit("frame_done", fd, cur.fd);
        check_bit("busy", busy, cur.busy);
        check_bit("in_ready", bus.in_ready, m_ready);
        if (cur.fd) check_val("word_at_done", int'(sr), int'(m_word));
        if (en) begin
            if (!prev_en) begin
                en_rises++;
                rise_cyc.push_back(cyc);
                last_low   = low_run;
                stream_cap = {{(W-1){1'b0}}, d};
            end else begin
                stream_cap = {stream_cap[W-2:0], d};
            end
            low_run = 0;
        end else begin
            low_run++;
        end
        if (fd) fd_count++;
        prev_en = en;
    end

    task automatic send(input logic [W-1:0] dat, input logic dr);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = dat;
        bus.in_dir   = dr;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_bit("ready_timeout", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        bus.in_dir   = 1'($urandom);
    endtask

    // Waits for frame_done while scrambling the word inputs every cycle.
    task automatic wait_fd();
        int n        = 0;
        int rdy_seen = 0;
        while (fd !== 1'b1 && n < 200) begin
            @(posedge clk);
            #2;
            if (fd !== 1'b1 && bus.in_ready === 1'b1) rdy_seen++;
            bus.in_data = W'($urandom);
            bus.in_dir  = 1'($urandom);
            n++;
        end
        if (n >= 200) check_bit("done_timeout", fd, 1'b1);
        check_val("ready_mid_frame", rdy_seen, 0);
    endtask

    task automatic wait_rise(input int target);
        int n = 0;
        while (en_rises < target && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 200) check_val("rise_timeout", en_rises, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t tbl[6];
        int   r0;
        int   f0;

        tbl[0] = '{data: 16'hA5C3, dir: 1'b0, stream: 16'hA5C3};
        tbl[1] = '{data: 16'h8001, dir: 1'b1, stream: 16'h8001};
        tbl[2] = '{data: 16'h1234, dir: 1'b1, stream: 16'h2C48};
        tbl[3] = '{data: 16'hFFFF, dir: 1'b0, stream: 16'hFFFF};
        tbl[4] = '{data: 16'h0F0F, dir: 1'b1, stream: 16'hF0F0};
        tbl[5] = '{data: 16'h0001, dir: 1'b0, stream: 16'h0001};

        // Reset held 3 cycles with a word offered: nothing may happen.
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h5555;
        bus.in_dir   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_bit("rst_en", en, 1'b0);
        check_bit("rst_ready", bus.in_ready, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", fd, 1'b0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        check_bit("ready_after_rst", bus.in_ready, 1'b1);

        // Directed frames from the vector table.
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].data, tbl[i].dir);
            wait_fd();
            check_val("tbl_stream", int'(stream_cap), int'(tbl[i].stream));
            check_val("tbl_word", int'(sr), int'(tbl[i].data));
            check_bit("tbl_dir", dir, tbl[i].dir);
        end

        // Back-to-back with in_valid held high.
        @(negedge clk);
        r0           = en_rises;
        f0           = fd_count;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        bus.in_dir   = 1'b0;
        wait_rise(r0 + 1);
        @(negedge clk);
        bus.in_data = 16'hFFFF;
        wait_rise(r0 + 2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (rise_cyc.size() >= 2)
            check_val("b2b_period", rise_cyc[$] - rise_cyc[$-1], W + G + 1);
        check_val("b2b_en_low", last_low, G + 1);
        check_val("b2b_done_count", fd_count - f0, 1);
        wait_fd();
        check_val("b2b_word", int'(sr), 16'hFFFF);

        // Reset right after shift 7 of 0x00FF.
        wait_rise(en_rises);
        f0 = fd_count;
        send(16'h00FF, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check_bit("midrst_en", en, 1'b0);
        check_bit("midrst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #2;
        check_val("midrst_no_done", fd_count - f0, 0);
        send(16'h0F0F, 1'b0);
        wait_fd();
        check_val("post_rst_stream", int'(stream_cap), 16'h0F0F);
        check_val("post_rst_word", int'(sr), 16'h0F0F);

        // Randomized traffic with occasional resets; the monitor does the checking.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = W'($urandom);
            bus.in_dir   = 1'($urandom);
            rst          = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
